// File: rtl/onchip_memory_dp_if.sv
// Avalon-MM slave port bundle for the dual-port on-chip RAM.
// The master modport drives requests, the slave modport answers them.
interface onchip_memory_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, byteenable, chipselect,
        output read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect,
        input  read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_memory_dp.sv
// Dual-port on-chip RAM, two Avalon-MM slaves, byte lanes,
// 1/2-cycle read latency and an optional zero-fill after reset.
module onchip_memory_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 14,
    parameter int DEPTH          = 16384,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clken,
    input  logic reset_req,
    onchip_memory_dp_if.slave s1,
    onchip_memory_dp_if.slave s2,
    output logic busy
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RL = READ_LATENCY;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state;
    logic [IW-1:0]   clr_addr;
    logic            en;
    logic            wait_req;
    logic            clr_we;

    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [IW-1:0]         idx   [2];
    logic [NB-1:0]         be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [1:0]            cs, rd, wr;
    logic [1:0]            in_rng, acc_rd, acc_wr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [RL-1:0]         vld [2];
    logic [DATA_WIDTH-1:0] dat [2][RL];

    assign en       = clken & ~reset_req;
    assign wait_req = (state == CLEAR) | ~en;
    assign clr_we   = (state == CLEAR) & en;

    always_comb begin
        addr[0]  = s1.address;
        addr[1]  = s2.address;
        be[0]    = s1.byteenable;
        be[1]    = s2.byteenable;
        wdata[0] = s1.writedata;
        wdata[1] = s2.writedata;
        cs       = {s2.chipselect, s1.chipselect};
        rd       = {s2.read, s1.read};
        wr       = {s2.write, s1.write};
        for (int p = 0; p < 2; p++) begin
            idx[p]    = IW'(addr[p]);
            in_rng[p] = {1'b0, addr[p]} < (ADDR_WIDTH+1)'(DEPTH);
            acc_wr[p] = cs[p] & wr[p] & ~wait_req;
            // read together with write on one port: write only
            acc_rd[p] = cs[p] & rd[p] & ~wr[p] & ~wait_req;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR_ON_RESET ? CLEAR : RUN;
            busy     <= CLEAR_ON_RESET;
            clr_addr <= '0;
        end else if (clr_we) begin
            if (clr_addr == IW'(DEPTH - 1)) begin
                state <= RUN;
                busy  <= 1'b0;
            end else begin
                clr_addr <= clr_addr + IW'(1);
            end
        end
    end

    // s2 first so s1 takes lanes both ports enable
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        for (int p = 1; p >= 0; p--) begin
            if (acc_wr[p] && in_rng[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[p][b])
                        mem[idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                vld[p] <= '0;
                for (int s = 0; s < RL; s++)
                    dat[p][s] <= '0;
            end
        end else if (clken) begin
            for (int p = 0; p < 2; p++) begin
                vld[p][0] <= acc_rd[p];
                if (acc_rd[p])
                    dat[p][0] <= in_rng[p] ? mem[idx[p]] : '0;
                for (int s = 1; s < RL; s++) begin
                    vld[p][s] <= vld[p][s-1];
                    if (vld[p][s-1])
                        dat[p][s] <= dat[p][s-1];
                end
            end
        end
    end

    assign s1.readdata      = dat[0][RL-1];
    assign s2.readdata      = dat[1][RL-1];
    assign s1.readdatavalid = vld[0][RL-1] & clken;
    assign s2.readdatavalid = vld[1][RL-1] & clken;
    assign s1.waitrequest   = wait_req;
    assign s2.waitrequest   = wait_req;
endmodule

// File: tb/tb_onchip_memory_dp.sv
// Directed bench: dut_a (16 words, latency 1, clear on reset)
// and dut_b (12 words, latency 2, no clear).
module tb_onchip_memory_dp;
    logic clk;
    logic reset_n;
    logic clken;
    logic reset_req;
    logic busy_a;
    logic busy_b;

    int checks = 0;
    int errors = 0;

    onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) a1 ();
    onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) a2 ();
    onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b1 ();
    onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b2 ();

    onchip_memory_dp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .reset_req(reset_req), .s1(a1), .s2(a2), .busy(busy_a)
    );

    onchip_memory_dp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12),
        .READ_LATENCY(2), .CLEAR_ON_RESET(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .reset_req(reset_req), .s1(b1), .s2(b2), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        a1.chipselect = 0; a1.read = 0; a1.write = 0;
        a2.chipselect = 0; a2.read = 0; a2.write = 0;
        b1.chipselect = 0; b1.read = 0; b1.write = 0;
        b2.chipselect = 0; b2.read = 0; b2.write = 0;
        a1.address = '0; a2.address = '0;
        b1.address = '0; b2.address = '0;
        a1.byteenable = '1; a2.byteenable = '1;
        b1.byteenable = '1; b2.byteenable = '1;
        a1.writedata = '0; a2.writedata = '0;
        b1.writedata = '0; b2.writedata = '0;
    endtask

    task automatic wr_a1(input logic [4:0] ad, input logic [31:0] d,
                         input logic [3:0] be);
        a1.chipselect = 1; a1.write = 1; a1.address = ad;
        a1.writedata = d; a1.byteenable = be;
        tick;
        a1.chipselect = 0; a1.write = 0;
    endtask

    task automatic rd_a1(input logic [4:0] ad, output logic [31:0] d,
                         output logic v);
        a1.chipselect = 1; a1.read = 1; a1.address = ad;
        tick;
        d = a1.readdata;
        v = a1.readdatavalid;
        a1.chipselect = 0; a1.read = 0;
    endtask

    task automatic wr_b1(input logic [3:0] ad, input logic [31:0] d);
        b1.chipselect = 1; b1.write = 1; b1.address = ad;
        b1.writedata = d; b1.byteenable = 4'hF;
        tick;
        b1.chipselect = 0; b1.write = 0;
    endtask

    task automatic rd_b1(input logic [3:0] ad, output logic [31:0] d,
                         output logic v);
        b1.chipselect = 1; b1.read = 1; b1.address = ad;
        tick;
        b1.chipselect = 0; b1.read = 0;
        tick;
        d = b1.readdata;
        v = b1.readdatavalid;
    endtask

    task automatic test_reset;
        reset_n = 0; clken = 1; reset_req = 0;
        idle_all;
        repeat (2) tick;
        checks++;
        if (a1.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_a1: got %b want 1", a1.waitrequest);
        end
        checks++;
        if (a2.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_a2: got %b want 1", a2.waitrequest);
        end
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_a: got %b want 1", busy_a);
        end
        checks++;
        if (a1.readdatavalid !== 1'b0 || a1.readdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rd_a1: got %b/%h want 0/0",
                     a1.readdatavalid, a1.readdata);
        end
        checks++;
        if (b1.readdatavalid !== 1'b0 || b1.readdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rd_b1: got %b/%h want 0/0",
                     b1.readdatavalid, b1.readdata);
        end
        checks++;
        if (busy_b !== 1'b0 || b1.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL rst_b_idle: got busy %b wait %b want 0 0",
                     busy_b, b1.waitrequest);
        end
        clken = 0;
        #1;
        checks++;
        if (b1.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rst_b_clken: got %b want 1", b1.waitrequest);
        end
        clken = 1; reset_req = 1;
        #1;
        checks++;
        if (b1.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rst_b_rreq: got %b want 1", b1.waitrequest);
        end
        reset_req = 0;
        #1;
    endtask

    task automatic test_clear;
        int n;
        reset_n = 1;
        n = 0;
        while (a1.waitrequest === 1'b1 && n < 100) begin
            n++;
            tick;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL clear_len: got %0d want 16", n);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL clear_busy: got %b want 0", busy_a);
        end
    endtask

    task automatic test_byteenable;
        logic [31:0] d;
        logic v;
        wr_a1(5'd5, 32'hAABBCCDD, 4'hF);
        wr_a1(5'd5, 32'h11223344, 4'b0101);
        rd_a1(5'd5, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL byteen: got %b/%h want 1/aa22cc44", v, d);
        end
        tick;
        checks++;
        if (a1.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL byteen_pulse: got %b want 0", a1.readdatavalid);
        end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        logic v;
        a1.chipselect = 1; a1.write = 1; a1.address = 5'd7;
        a1.writedata = 32'h000000FF; a1.byteenable = 4'b0001;
        a2.chipselect = 1; a2.write = 1; a2.address = 5'd7;
        a2.writedata = 32'h0000AB00; a2.byteenable = 4'b0011;
        tick;
        a1.chipselect = 0; a1.write = 0;
        a2.chipselect = 0; a2.write = 0;
        rd_a1(5'd7, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h0000ABFF) begin
            errors++;
            $display("FAIL collision: got %b/%h want 1/0000abff", v, d);
        end
    endtask

    task automatic test_rdw;
        logic [31:0] d;
        logic v;
        a1.chipselect = 1; a1.write = 1; a1.address = 5'd5;
        a1.writedata = 32'hCAFEF00D; a1.byteenable = 4'hF;
        a2.chipselect = 1; a2.read = 1; a2.address = 5'd5;
        tick;
        a1.chipselect = 0; a1.write = 0;
        a2.chipselect = 0; a2.read = 0;
        checks++;
        if (a2.readdatavalid !== 1'b1 || a2.readdata !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL rdw_old: got %b/%h want 1/aa22cc44",
                     a2.readdatavalid, a2.readdata);
        end
        rd_a1(5'd5, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rdw_new: got %b/%h want 1/cafef00d", v, d);
        end
        a1.chipselect = 1; a1.read = 1; a1.write = 1;
        a1.address = 5'd9; a1.writedata = 32'h12345678;
        tick;
        a1.chipselect = 0; a1.read = 0; a1.write = 0;
        checks++;
        if (a1.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL rw_novalid: got %b want 0", a1.readdatavalid);
        end
        rd_a1(5'd9, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h12345678) begin
            errors++;
            $display("FAIL rw_write: got %b/%h want 1/12345678", v, d);
        end
    endtask

    task automatic test_stall;
        a1.chipselect = 1; a1.read = 1; a1.address = 5'd9;
        tick;
        a1.chipselect = 0; a1.read = 0;
        clken = 0;
        #1;
        checks++;
        if (a1.waitrequest !== 1'b1 || a2.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL stall_wait: got %b %b want 1 1",
                     a1.waitrequest, a2.waitrequest);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a1.readdatavalid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got %b want 0",
                         i, a1.readdatavalid);
            end
            if (i < 2) tick;
        end
        tick;
        clken = 1;
        #1;
        checks++;
        if (a1.readdatavalid !== 1'b1 || a1.readdata !== 32'h12345678) begin
            errors++;
            $display("FAIL stall_out: got %b/%h want 1/12345678",
                     a1.readdatavalid, a1.readdata);
        end
        tick;
        checks++;
        if (a1.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL stall_once: got %b want 0", a1.readdatavalid);
        end
    endtask

    task automatic test_latency;
        logic [31:0] exp_d [3];
        logic [2:0]  exp_v;
        exp_d[0] = 32'h1; exp_d[1] = 32'h2; exp_d[2] = 32'h3;
        exp_v = 3'b111;
        wr_b1(4'd1, 32'h1);
        wr_b1(4'd2, 32'h2);
        wr_b1(4'd3, 32'h3);
        b1.chipselect = 1; b1.read = 1; b1.address = 4'd1;
        tick;
        checks++;
        if (b1.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: got %b want 0", b1.readdatavalid);
        end
        b1.address = 4'd2;
        tick;
        b1.address = 4'd3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b1.readdatavalid !== exp_v[i] || b1.readdata !== exp_d[i]) begin
                errors++;
                $display("FAIL lat_word%0d: got %b/%h want 1/%h",
                         i, b1.readdatavalid, b1.readdata, exp_d[i]);
            end
            if (i == 0) begin
                tick;
                b1.chipselect = 0; b1.read = 0;
            end else begin
                tick;
            end
        end
        checks++;
        if (b1.readdatavalid !== 1'b0 || b1.readdata !== 32'h3) begin
            errors++;
            $display("FAIL lat_end: got %b/%h want 0/3",
                     b1.readdatavalid, b1.readdata);
        end
    endtask

    task automatic test_reset_req;
        b1.chipselect = 1; b1.read = 1; b1.address = 4'd2;
        tick;
        b1.address = 4'd3;
        reset_req = 1;
        #1;
        checks++;
        if (b1.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rreq_wait: got %b want 1", b1.waitrequest);
        end
        tick;
        checks++;
        if (b1.readdatavalid !== 1'b1 || b1.readdata !== 32'h2) begin
            errors++;
            $display("FAIL rreq_drain: got %b/%h want 1/2",
                     b1.readdatavalid, b1.readdata);
        end
        tick;
        checks++;
        if (b1.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL rreq_block: got %b want 0", b1.readdatavalid);
        end
        b1.chipselect = 0; b1.read = 0;
        reset_req = 0;
        tick;
        checks++;
        if (b1.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL rreq_late: got %b want 0", b1.readdatavalid);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] d;
        logic v;
        for (int i = 0; i < 12; i++)
            wr_b1(4'(i), 32'h100 + 32'(i));
        wr_b1(4'd13, 32'hDEADBEEF);
        rd_b1(4'd13, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: got %b/%h want 1/0", v, d);
        end
        for (int i = 0; i < 12; i++) begin
            rd_b1(4'(i), d, v);
            checks++;
            if (v !== 1'b1 || d !== 32'h100 + 32'(i)) begin
                errors++;
                $display("FAIL oor_word%0d: got %b/%h want 1/%h",
                         i, v, d, 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        logic [31:0] d;
        logic v;
        int n;
        for (int i = 0; i < 16; i++)
            wr_a1(5'(i), 32'h01010101 * 32'(i + 1), 4'hF);
        reset_n = 0;
        tick;
        reset_n = 1;
        repeat (8) tick;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b want 1", busy_a);
        end
        reset_n = 0;
        #1;
        checks++;
        if (a1.waitrequest !== 1'b1 || a1.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: got wait %b vld %b want 1 0",
                     a1.waitrequest, a1.readdatavalid);
        end
        tick;
        reset_n = 1;
        n = 0;
        while (a1.waitrequest === 1'b1 && n < 100) begin
            n++;
            tick;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL mid_len: got %0d want 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            rd_a1(5'(i), d, v);
            checks++;
            if (v !== 1'b1 || d !== 32'h0) begin
                errors++;
                $display("FAIL mid_zero%0d: got %b/%h want 1/0", i, v, d);
            end
        end
        rd_a1(5'd20, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL a_oor: got %b/%h want 1/0", v, d);
        end
    endtask

    initial begin
        test_reset;
        test_clear;
        test_byteenable;
        test_collision;
        test_rdw;
        test_stall;
        test_latency;
        test_reset_req;
        test_out_of_range;
        test_reset_mid_clear;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/onchip_memory_dp.md
# onchip_memory_dp

Parametrised dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2), byte enables, selectable read latency, clock-enable/reset-request gating and an optional hardware clear sequence that zeroes the whole array after reset. It is the drop-in program/data memory for the Nios II system when a second master (DMA, video/game logic) needs concurrent access. Its contents are deterministic after every reset without an init file.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; a multiple of 8.
- ADDR_WIDTH, 14, word-address width per port.
- DEPTH, 16384, number of words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read accept to data; legal values 1 or 2.
- CLEAR_ON_RESET, 1, when 1 the array is zeroed after every reset.

Ports:
- clk  in  1  single clock for both ports.
- reset_n  in  1  asynchronous, active-low reset.
- clken  in  1  global clock enable; 0 stalls the block.
- reset_req  in  1  1 blocks new accesses, as clken=0 does.
- sN_address  in  ADDR_WIDTH  word address (N = 1, 2).
- sN_byteenable  in  DATA_WIDTH/8  write byte lanes.
- sN_chipselect, sN_read, sN_write  in  1  Avalon controls.
- sN_writedata  in  DATA_WIDTH  write data.
- sN_readdata  out  DATA_WIDTH  read data.
- sN_readdatavalid  out  1  one-cycle pulse with each read's data.
- sN_waitrequest  out  1  1 means the request is not accepted.
- busy  out  1  1 while the clear sequence runs.

## Operation
- FSM with two states, CLEAR and RUN. After reset the FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- CLEAR: an internal counter writes zero to addresses 0..DEPTH-1, one per enabled cycle, all lanes. After address DEPTH-1 is written, the FSM moves to RUN. The counter freezes while clken=0 or reset_req=1.
- sN_waitrequest = (state==CLEAR) | ~clken | reset_req. It is not gated by chipselect.
- Accept condition: sN_chipselect & (sN_read | sN_write) & ~sN_waitrequest.
- Write: only lanes with byteenable=1 are updated. Other lanes keep their old value.
- Read and write asserted together on one port is illegal. The block performs the write, ignores the read, and raises no readdatavalid.
- Address ≥ DEPTH: a write is dropped. A read returns all-zero data with a normal readdatavalid.
- Same-cycle writes to the same address from both ports: in lanes both ports enable, s1 wins. Each port's other enabled lanes are written normally.
- Read during write, same port or the other port, same cycle and same address: the read returns the old data.
- Reads are fully pipelined: one read per port per cycle is accepted.

## Timing
- Reset values:
  - sN_readdata = 0, sN_readdatavalid = 0.
  - busy = CLEAR_ON_RESET.
  - sN_waitrequest = 1 if CLEAR_ON_RESET=1; otherwise it follows ~clken | reset_req.
- Clear duration: DEPTH enabled cycles. busy and waitrequest fall on the cycle after the write to address DEPTH-1.
- Read latency: for a read accepted at edge k, readdata and readdatavalid are valid in cycle k+READ_LATENCY, for one cycle. readdata holds its value afterwards.
- clken=0 freezes the read pipeline in place; held data and valids are not lost or duplicated. With clken=0, readdatavalid stays 0 until the pipeline advances.
- reset_req=1 with clken=1: no new accepts, and in-flight reads drain normally.
- reset_n asserted mid-operation: the pipeline and valids clear immediately and the FSM re-enters CLEAR (if enabled). Array contents are undefined until the clear completes.
- Write to read-back: a write accepted at edge k is visible to a read accepted at edge k+1.

## Test plan
- Clear: reset with DEPTH=16, CLEAR_ON_RESET=1 -> waitrequest=1 for exactly 16 cycles. Reads of addresses 0..15 then return 0x00000000.
- Byte enables: write 0xAABBCCDD to address 5 with byteenable=4'hF, then 0x11223344 with byteenable=4'b0101 -> read of address 5 returns 0xAA22CC44.
- Latency: READ_LATENCY=2, back-to-back reads of addresses 1, 2, 3 (preloaded 0x1, 0x2, 0x3) -> readdatavalid high on three consecutive cycles starting 2 cycles after the first accept, data 0x1, 0x2, 0x3.
- Collision: s1 writes 0x000000FF with byteenable 4'b0001 and s2 writes 0x0000AB00 with byteenable 4'b0011 to address 7 in the same cycle -> address 7 reads 0x0000ABFF.
- Stall: clken=0 for 3 cycles immediately after a read accept -> readdatavalid is delayed by exactly 3 cycles and appears once. Waitrequest is 1 on both ports during the stall.
- Reset mid-clear and out-of-range: assert reset_n low at clear cycle 8 -> clear restarts at address 0 and takes the full DEPTH cycles. With DEPTH=12 and ADDR_WIDTH=4, a read of address 13 returns 0 and a write to address 13 changes no word.
